// File: rtl/dmem_responder_if.sv
// Load/store bus between the core memory stage and the data-memory responder.
// No latency of its own: it only groups the request and response handshake wires.
// Backpressure: req_ready stalls the master; rsp_ready stalls the slave.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: B/H/W loads (sign/zero extended) and lane-masked stores on a word array.
// Latency: response visible WAIT_CYCLES+1 cycles after acceptance; one request in flight.
// Backpressure: req_ready low outside IDLE; response held frozen until rsp_ready.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  dmem_responder_if.slave io_mem
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  req_t        r_req;
  req_t        w_cur;
  logic        r_req_rdy;
  logic        r_rsp_vld;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_wait_done;
  logic        w_do_access;
  logic [29:0] w_widx;
  logic [AW-1:0] w_midx;
  logic        w_fault;
  logic [31:0] w_word;
  logic [31:0] w_byte_src;
  logic [31:0] w_half_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wpos;

  logic [31:0] r_mem [DEPTH_WORDS];

  assign w_accept    = io_mem.req_valid && r_req_rdy;
  assign w_wait_done = (r_state == S_WAIT) && (r_cnt <= 4'd1);
  // With no wait states the access happens on the acceptance edge itself.
  assign w_do_access = (WAIT_CYCLES == 0) ? w_accept : w_wait_done;

  // Request being executed: live inputs at acceptance, latched copy afterwards.
  always_comb begin
    w_cur = r_req;
    if (r_state == S_IDLE) begin
      w_cur.we    = io_mem.req_we;
      w_cur.addr  = io_mem.req_addr;
      w_cur.wdata = io_mem.req_wdata;
      w_cur.ctrl  = io_mem.req_ctrl;
    end
  end

  assign w_widx = w_cur.addr[31:2];
  assign w_midx = w_widx[AW-1:0];
  assign w_word = r_mem[w_midx];

  // Fault decode: range, alignment, illegal funct3, and unsigned store widths.
  always_comb begin
    w_fault = ({2'b00, w_widx} >= 32'(DEPTH_WORDS));
    unique case (w_cur.ctrl)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (w_cur.addr[0]) w_fault = 1'b1;
      3'b010:         if (w_cur.addr[1:0] != 2'b00) w_fault = 1'b1;
      default:        w_fault = 1'b1;
    endcase
    if (w_cur.we && (w_cur.ctrl == 3'b100 || w_cur.ctrl == 3'b101)) w_fault = 1'b1;
  end

  assign w_byte_src = w_word >> {w_cur.addr[1:0], 3'b000};
  assign w_half_src = w_word >> {w_cur.addr[1], 4'b0000};
  assign w_byte     = w_byte_src[7:0];
  assign w_half     = w_half_src[15:0];

  // Load lane select and extension; little-endian lanes.
  always_comb begin
    w_load = 32'd0;
    unique case (w_cur.ctrl)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      3'b010:  w_load = w_word;
      default: w_load = 32'd0;
    endcase
  end

  // Store lane enables and data replicated into every candidate lane.
  always_comb begin
    w_be   = 4'b0000;
    w_wpos = w_cur.wdata;
    unique case (w_cur.ctrl)
      3'b000: begin
        w_be   = 4'b0001 << w_cur.addr[1:0];
        w_wpos = {4{w_cur.wdata[7:0]}};
      end
      3'b001: begin
        w_be   = 4'b0011 << {w_cur.addr[1], 1'b0};
        w_wpos = {2{w_cur.wdata[15:0]}};
      end
      3'b010:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Next-state and wait counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
        if (w_wait_done) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (io_mem.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM, counter, request latch and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_req     <= '0;
      r_req_rdy <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req_rdy <= (w_state_nxt == S_IDLE);
      r_rsp_vld <= (w_state_nxt == S_RESP);
      if (w_accept) r_req <= w_cur;
      if (w_do_access) begin
        r_err   <= w_fault;
        r_rdata <= (w_fault || w_cur.we) ? 32'd0 : w_load;
      end else if (r_state == S_RESP && io_mem.rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Array write on the access edge; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_do_access && w_cur.we && !w_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_midx][i*8 +: 8] <= w_wpos[i*8 +: 8];
      end
    end
  end

  assign io_mem.req_ready = r_req_rdy;
  assign io_mem.rsp_valid = r_rsp_vld;
  assign io_mem.rsp_rdata = r_rdata;
  assign io_mem.rsp_err   = r_err;

endmodule
